bayer_dpc_5x5: RTL and testbench
================================

Name: bayer_dpc_5x5

Overview:
- Defective-pixel-correction stage that sits directly downstream of the 5x5 sliding-window stage.
- Consumes the nine same-colour Bayer taps of each window: the centre and its 8 neighbours at distance 2.
- Flags a hot or cold centre pixel against a programmable threshold and replaces it with the rounded neighbour average.
- Fixed-latency pipeline that passes valid and end-of-frame alongside the data, and keeps a per-frame defect count.

Parameters:
- DATA_W, 16, pixel width.
- CNT_W, 20, width of the per-frame defect counter.

Ports:
- isp_clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- Din11, Din13, Din15, Din31, Din35, Din51, Din53, Din55  in  DATA_W each  same-colour neighbours (row/column of the window).
- Din33  in  DATA_W  centre pixel.
- inEn  in  1  window valid, qualifies all Din in the same cycle.
- endFlagIn  in  1  last pixel of the frame, qualified by inEn.
- cfg_thr  in  DATA_W  detection threshold.
- cfg_bypass  in  1  1 = pass the centre pixel unmodified.
- dataOut  out  DATA_W  corrected pixel.
- outEn  out  1  dataOut valid.
- endFlag  out  1  delayed endFlagIn.
- defectCnt  out  CNT_W  defects corrected in the last completed frame.

Behaviour:
- Reset: dataOut=0, outEn=0, endFlag=0, defectCnt=0; all pipeline data and valid registers cleared; internal counter=0; idle=1; thr_s=0; byp_s=1.
- Reset asserted mid-frame: in-flight pixels are discarded and outEn is guaranteed low from the reset edge.
- Pipeline advances every clock; it is not stalled by inEn. Valid and end-of-frame bits travel with the data.
- Latency: inEn high at edge k gives outEn/dataOut/endFlag high after edge k+3, i.e. 4 register stages. Back-to-back inputs produce back-to-back outputs with no bubbles.
- S1: register the centre, the 4 pairwise max/min of the neighbours, and the 4 pairwise sums (DATA_W+1 bits).
- S2: form 2 max, 2 min and 2 sums (DATA_W+2 bits).
- S3: form global max, global min and the total sum (DATA_W+3 bits); carry the centre.
- S4 decision, computed in DATA_W+1 bits with no wrap:
  - hot = centre > max + thr_s.
  - cold = centre + thr_s < min.
  - hot and cold are mutually exclusive.
  - If (hot or cold) and byp_s=0: dataOut = (sum + 4) >> 3, which always fits DATA_W.
  - Otherwise dataOut = centre.
- dataOut holds its value when outEn=0; downstream ignores it.
- Config shadowing:
  - While idle=1, thr_s and byp_s load cfg_thr and cfg_bypass every clock.
  - idle clears on the first inEn and sets on the cycle after endFlag output.
  - Result: config changes mid-frame take effect from the next frame.
- Defect counter:
  - Increments when an S4 valid pixel is corrected; saturates at all-ones.
  - In the endFlag output cycle, defectCnt loads the final count, including that pixel, and the counter clears to 0.
  - In bypass, nothing is corrected and the counter stays 0.
- endFlagIn without inEn is ignored.
- Equal-threshold boundary: centre == max + thr is not a defect; centre + thr == min is not a defect.
- thr=0, all neighbours equal, centre differs by 1: the pixel is corrected.

Test Plan:
- Flat field, all taps 0x0100, thr=0x0040, one inEn pulse → outEn exactly 4 edges later, dataOut=0x0100, no defect.
- Hot pixel: neighbours 0x0100, centre 0xFFFF, thr=0x0040 → dataOut=0x0100. Same with centre 0x0140 (boundary) → dataOut=0x0140 uncorrected; centre 0x0141 → corrected.
- Cold pixel with rounding: neighbours 0x0200×7 and 0x0203, centre 0x0000, thr=0x0010 → sum=0x1003, dataOut=(0x1003+4)>>3=0x0200. Max-value neighbours 0xFFFF and centre 0 → dataOut=0xFFFF with no overflow.
- Bypass and shadowing: cfg_bypass=1 for frame 1 with 3 hot pixels → centre passed, defectCnt=0. cfg_bypass toggled to 0 mid-frame-1 → bypass remains until endFlag. Frame 2 with the same stimulus → defectCnt=3 after endFlag.
- Streaming: 1000 consecutive inEn with random taps vs a reference model → bit-exact. endFlagIn on the last pixel → endFlag 4 edges later; defectCnt updates that cycle; the next frame's count restarts at 0.
- Reset pulse while 3 pixels are in flight → outEn stays 0 and all outputs 0. The first post-reset frame uses the new cfg values.

Source files
------------

// File: rtl/bayer_dpc_5x5.sv
// bayer_dpc_5x5: 4-stage defective-pixel correction over 9 same-colour taps (Din*: taps, Din33 centre; inEn/endFlagIn in; cfg_thr/cfg_bypass shadowed per frame; dataOut/outEn/endFlag/defectCnt out)
module bayer_dpc_5x5 #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 20
) (
  input  logic              isp_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Din11,
  input  logic [DATA_W-1:0] Din13,
  input  logic [DATA_W-1:0] Din15,
  input  logic [DATA_W-1:0] Din31,
  input  logic [DATA_W-1:0] Din33,
  input  logic [DATA_W-1:0] Din35,
  input  logic [DATA_W-1:0] Din51,
  input  logic [DATA_W-1:0] Din53,
  input  logic [DATA_W-1:0] Din55,
  input  logic              inEn,
  input  logic              endFlagIn,
  input  logic [DATA_W-1:0] cfg_thr,
  input  logic              cfg_bypass,
  output logic [DATA_W-1:0] dataOut,
  output logic              outEn,
  output logic              endFlag,
  output logic [CNT_W-1:0]  defectCnt
);
  localparam int W = DATA_W;
  logic [W-1:0] nb [8];
  logic [W-1:0] c1, c2, c3, mx3, mn3, thr_s;
  logic [W-1:0] mx1 [4], mn1 [4], mx2 [2], mn2 [2];
  logic [W:0] s1 [4];
  logic [W+1:0] s2 [2];
  logic [W+2:0] s3, rnd;
  logic [W:0] hi, lo;
  logic [2:0] v, e;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic byp_s, idle, fix;
  assign nb = '{Din11, Din13, Din15, Din31, Din35, Din51, Din53, Din55};
  assign hi = {1'b0, mx3} + {1'b0, thr_s};
  assign lo = {1'b0, c3} + {1'b0, thr_s};
  assign fix = (({1'b0, c3} > hi) | (lo < {1'b0, mn3})) & ~byp_s;
  assign rnd = s3 + (W+3)'(4);
  assign cnt_nx = cnt + CNT_W'(v[2] & fix & ~(&cnt));
  always_ff @(posedge isp_clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      e <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
      for (int i = 0; i < 4; i++) begin
        mx1[i] <= '0;
        mn1[i] <= '0;
        s1[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        mx2[i] <= '0;
        mn2[i] <= '0;
        s2[i] <= '0;
      end
      mx3 <= '0;
      mn3 <= '0;
      s3 <= '0;
      dataOut <= '0;
      outEn <= 1'b0;
      endFlag <= 1'b0;
      defectCnt <= '0;
      cnt <= '0;
      idle <= 1'b1;
      thr_s <= '0;
      byp_s <= 1'b1;
    end else begin
      v <= {v[1:0], inEn};
      e <= {e[1:0], inEn & endFlagIn};
      c1 <= Din33;
      c2 <= c1;
      c3 <= c2;
      for (int i = 0; i < 4; i++) begin
        mx1[i] <= nb[2*i] > nb[2*i+1] ? nb[2*i] : nb[2*i+1];
        mn1[i] <= nb[2*i] < nb[2*i+1] ? nb[2*i] : nb[2*i+1];
        s1[i] <= {1'b0, nb[2*i]} + {1'b0, nb[2*i+1]};
      end
      for (int i = 0; i < 2; i++) begin
        mx2[i] <= mx1[2*i] > mx1[2*i+1] ? mx1[2*i] : mx1[2*i+1];
        mn2[i] <= mn1[2*i] < mn1[2*i+1] ? mn1[2*i] : mn1[2*i+1];
        s2[i] <= {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
      end
      mx3 <= mx2[0] > mx2[1] ? mx2[0] : mx2[1];
      mn3 <= mn2[0] < mn2[1] ? mn2[0] : mn2[1];
      s3 <= {1'b0, s2[0]} + {1'b0, s2[1]};
      outEn <= v[2];
      endFlag <= e[2];
      if (v[2]) dataOut <= fix ? rnd[W+2:3] : c3;
      if (e[2]) defectCnt <= cnt_nx;
      cnt <= e[2] ? '0 : cnt_nx;
      // config is only resampled between frames, once the last pixel has left
      if (endFlag) idle <= 1'b1;
      else if (inEn) idle <= 1'b0;
      if (idle) begin
        thr_s <= cfg_thr;
        byp_s <= cfg_bypass;
      end
    end
  end
endmodule

// File: tb/tb_bayer_dpc_5x5.sv
// tb_bayer_dpc_5x5: random and directed stimulus checked against a per-frame behavioural model
module tb_bayer_dpc_5x5;
  logic isp_clk = 0, rst_n = 0, inEn = 0, endFlagIn = 0, cfg_bypass = 0;
  logic [15:0] nb_t [8];
  logic [15:0] c_t = 0, cfg_thr = 16'h40, dataOut;
  logic outEn, endFlag;
  logic [19:0] defectCnt;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct {logic [15:0] d; logic e; logic f; int due;} exp_t;
  exp_t q[$];
  logic new_frame = 1, fbyp = 0;
  logic [15:0] fthr = 0;
  int mcnt = 0, exp_dc = 0;

  bayer_dpc_5x5 dut (
    .isp_clk(isp_clk), .rst_n(rst_n),
    .Din11(nb_t[0]), .Din13(nb_t[1]), .Din15(nb_t[2]), .Din31(nb_t[3]),
    .Din33(c_t), .Din35(nb_t[4]), .Din51(nb_t[5]), .Din53(nb_t[6]), .Din55(nb_t[7]),
    .inEn(inEn), .endFlagIn(endFlagIn), .cfg_thr(cfg_thr), .cfg_bypass(cfg_bypass),
    .dataOut(dataOut), .outEn(outEn), .endFlag(endFlag), .defectCnt(defectCnt)
  );

  always #5 isp_clk = ~isp_clk;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, x, cyc);
    end
  endfunction

  // {corrected, pixel} from the window rules: hot/cold against max/min with threshold
  function automatic logic [16:0] ref_px(input logic [15:0] n [8], input logic [15:0] c, thr, input logic byp);
    int mx, mn, sum;
    logic f;
    mx = 0; mn = 65535; sum = 0;
    foreach (n[i]) begin
      if (int'(n[i]) > mx) mx = int'(n[i]);
      if (int'(n[i]) < mn) mn = int'(n[i]);
      sum += int'(n[i]);
    end
    f = ((int'(c) > mx + int'(thr)) || (int'(c) + int'(thr) < mn)) && !byp;
    return {f, f ? 16'((sum + 4) / 8) : c};
  endfunction

  always @(posedge isp_clk) begin
    cyc++;
    if (!rst_n) new_frame = 1;
    else if (inEn) begin
      logic [16:0] r;
      if (new_frame) begin
        fthr = cfg_thr;
        fbyp = cfg_bypass;
        new_frame = 0;
      end
      r = ref_px(nb_t, c_t, fthr, fbyp);
      q.push_back('{r[15:0], endFlagIn, r[16], cyc + 3});
      if (endFlagIn) new_frame = 1;
    end
  end

  always @(negedge isp_clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      exp_dc = 0;
      chk("rst_outputs", {outEn, endFlag, dataOut, defectCnt[13:0]}, 0);
      chk("rst_cnt_hi", 32'(defectCnt), 0);
    end else begin
      logic ev;
      ev = q.size() > 0 && q[0].due == cyc;
      chk("outEn", 32'(outEn), 32'(ev));
      if (ev) begin
        exp_t x;
        x = q.pop_front();
        chk("dataOut", 32'(dataOut), 32'(x.d));
        chk("endFlag", 32'(endFlag), 32'(x.e));
        if (x.f) mcnt++;
        if (x.e) begin
          exp_dc = mcnt;
          mcnt = 0;
        end
      end else chk("endFlag_idle", 32'(endFlag), 0);
      chk("defectCnt", 32'(defectCnt), 32'(exp_dc));
    end
  end

  task automatic px(input logic [15:0] c, input logic e);
    @(negedge isp_clk);
    inEn = 1;
    c_t = c;
    endFlagIn = e;
    @(posedge isp_clk);
    #1 inEn = 0;
    endFlagIn = 0;
  endtask

  task automatic flat(input logic [15:0] n, input logic [15:0] c, input logic e);
    foreach (nb_t[i]) nb_t[i] = n;
    px(c, e);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge isp_clk);
    #1;
  endtask

  task automatic rnd_px(input logic e);
    logic [15:0] base;
    base = 16'($urandom_range(0, 16'hFF00));
    foreach (nb_t[i]) nb_t[i] = ($urandom_range(0, 15) == 0) ? 16'($urandom) : base + 16'($urandom_range(0, 255));
    px(($urandom_range(0, 3) == 0) ? 16'($urandom) : base + 16'($urandom_range(0, 255)), e);
  endtask

  initial begin
    logic [15:0] t [8];
    foreach (nb_t[i]) nb_t[i] = 0;
    foreach (t[i]) t[i] = 16'h100;
    chk("model_hot", 32'(ref_px(t, 16'hFFFF, 16'h40, 0)), 32'h1_0100);
    chk("model_eq_hi", 32'(ref_px(t, 16'h140, 16'h40, 0)), 32'h0_0140);
    chk("model_hi1", 32'(ref_px(t, 16'h141, 16'h40, 0)), 32'h1_0100);
    chk("model_thr0", 32'(ref_px(t, 16'h101, 16'h0, 0)), 32'h1_0100);
    chk("model_eq_lo", 32'(ref_px(t, 16'hC0, 16'h40, 0)), 32'h0_00C0);
    foreach (t[i]) t[i] = 16'h200;
    t[7] = 16'h203;
    chk("model_round", 32'(ref_px(t, 16'h0, 16'h10, 0)), 32'h1_0200);
    foreach (t[i]) t[i] = 16'hFFFF;
    chk("model_max", 32'(ref_px(t, 16'h0, 16'h10, 0)), 32'h1_FFFF);
    repeat (4) @(posedge isp_clk);
    #1 chk("rst_outEn", 32'(outEn), 0);
    @(negedge isp_clk) rst_n = 1;
    gap(3);
    flat(16'h100, 16'h100, 0);
    gap(3);
    chk("lat_outEn", 32'(outEn), 1);
    chk("lat_data", 32'(dataOut), 16'h100);
    flat(16'h100, 16'hFFFF, 0);
    flat(16'h100, 16'h140, 0);
    flat(16'h100, 16'h141, 1);
    gap(6);
    chk("dc_frame_a", 32'(defectCnt), 2);
    cfg_thr = 16'h10;
    gap(2);
    foreach (nb_t[i]) nb_t[i] = 16'h200;
    nb_t[7] = 16'h203;
    px(16'h0, 0);
    gap(3);
    chk("round_data", 32'(dataOut), 16'h200);
    flat(16'hFFFF, 16'h0, 1);
    gap(3);
    chk("max_data", 32'(dataOut), 16'hFFFF);
    gap(3);
    chk("dc_frame_b", 32'(defectCnt), 2);
    @(negedge isp_clk) endFlagIn = 1;
    @(negedge isp_clk) endFlagIn = 0;
    cfg_thr = 16'h40;
    cfg_bypass = 1;
    gap(2);
    flat(16'h100, 16'hFFFF, 0);
    flat(16'h100, 16'h0, 0);
    cfg_bypass = 0;
    flat(16'h100, 16'h100, 0);
    flat(16'h100, 16'hF000, 1);
    gap(3);
    chk("byp_data", 32'(dataOut), 16'hF000);
    gap(3);
    chk("dc_bypass", 32'(defectCnt), 0);
    flat(16'h100, 16'hFFFF, 0);
    flat(16'h100, 16'h0, 0);
    flat(16'h100, 16'h100, 0);
    flat(16'h100, 16'hF000, 1);
    gap(6);
    chk("dc_after_byp", 32'(defectCnt), 3);
    cfg_thr = 16'($urandom_range(0, 16'h80));
    gap(2);
    for (int i = 0; i < 1000; i++) rnd_px(i == 999);
    gap(6);
    for (int i = 0; i < 3; i++) rnd_px(i == 2);
    gap(6);
    flat(16'h100, 16'hFFFF, 0);
    flat(16'h100, 16'hFFFF, 0);
    flat(16'h100, 16'hFFFF, 0);
    rst_n = 0;
    #1 chk("rst_mid_outEn", 32'(outEn), 0);
    chk("rst_mid_data", 32'(dataOut), 0);
    chk("rst_mid_dc", 32'(defectCnt), 0);
    cfg_thr = 16'h20;
    gap(3);
    @(negedge isp_clk) rst_n = 1;
    gap(2);
    flat(16'h100, 16'h130, 1);
    gap(3);
    chk("post_rst_cfg", 32'(dataOut), 16'h100);
    gap(3);
    chk("dc_post_rst", 32'(defectCnt), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
